sqrt_bus_master: RTL and testbench

Bus-initiator sequencer for the memory-mapped square-root peripheral. It accepts one operand through a valid/ready request port and runs the full transaction on the peripheral bus (`cs`/`rd`/`wr`/`addr`/`d_in`/`d_out`):

1. Write the operand.
2. Write the init strobe.
3. Poll the done register.
4. Read the result.

It returns the result through a valid/ready response port. It sits between a core-side command source (CPU glue or accelerator front end) and `peripheral_sqrt`, so the peripheral needs no software polling.

---
 rtl/sqrt_bus_pkg.sv | 21 ++
 rtl/sqrt_bus_master.sv | 144 ++++++++++++++
 tb/tb_sqrt_bus_master.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_bus_pkg.sv
// rtl/sqrt_bus_pkg.sv - shared FSM encoding and register map for the sqrt bus master
package sqrt_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_INIT,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_RD_DATA,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    localparam logic [4:0]  DEF_ADDR_A    = 5'h04;
    localparam logic [4:0]  DEF_ADDR_INIT = 5'h0C;
    localparam logic [4:0]  DEF_ADDR_DATA = 5'h10;
    localparam logic [4:0]  DEF_ADDR_DONE = 5'h14;
    localparam logic [15:0] INIT_STROBE   = 16'h0001;

endpackage

// File: rtl/sqrt_bus_master.sv
// rtl/sqrt_bus_master.sv - operand/init/poll/read sequencer for peripheral_sqrt
// SQRT_MASTER_TIMEOUT_EN compiles in a bounded poll counter that drives resp_error.
import sqrt_bus_pkg::*;

module sqrt_bus_master #(
    parameter logic [4:0] ADDR_A    = DEF_ADDR_A,
    parameter logic [4:0] ADDR_INIT = DEF_ADDR_INIT,
    parameter logic [4:0] ADDR_DATA = DEF_ADDR_DATA,
    parameter logic [4:0] ADDR_DONE = DEF_ADDR_DONE,
    parameter logic [7:0] MAX_POLLS = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [15:0] req_operand,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    input  logic        resp_ready,
    output logic        cs,
    output logic        rd,
    output logic        wr,
    output logic [4:0]  addr,
    output logic [15:0] d_in,
    input  logic [31:0] d_out
);

    state_t      state_q, state_d;
    logic [15:0] operand_q;
    logic        pending_q;
    logic        accept;
    logic        poll_last;
    logic        resp_error_q;
    logic        cs_d, rd_d, wr_d;
    logic [4:0]  addr_d;
    logic [15:0] d_in_d;

    assign accept     = req_valid & req_ready;
    assign resp_error = resp_error_q;

`ifdef SQRT_MASTER_TIMEOUT_EN
    logic [7:0] poll_cnt_q;

    // poll_last is true while the poll being evaluated is the MAX_POLLS-th one
    assign poll_last = (poll_cnt_q + 8'd1) == MAX_POLLS;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt_q <= '0;
        end else if (state_d == ST_WR_A) begin
            poll_cnt_q <= '0;
        end else if (state_q == ST_POLL_WAIT && !d_out[0]) begin
            poll_cnt_q <= poll_cnt_q + 8'd1;
        end
    end
`else
    logic unused_max_polls;
    assign unused_max_polls = ^MAX_POLLS;
    assign poll_last        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            // the accept cycle only latches the operand; the bus sequence starts one cycle later
            ST_IDLE:      if (pending_q) state_d = ST_WR_A;
            ST_WR_A:      state_d = ST_WR_INIT;
            ST_WR_INIT:   state_d = ST_POLL_RD;
            ST_POLL_RD:   state_d = ST_POLL_WAIT;
            ST_POLL_WAIT: begin
                if (d_out[0])       state_d = ST_RD_DATA;
                else if (poll_last) state_d = ST_RESP;
                else                state_d = ST_POLL_RD;
            end
            ST_RD_DATA:   state_d = ST_RD_WAIT;
            ST_RD_WAIT:   state_d = ST_RESP;
            ST_RESP:      if (resp_ready) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // bus strobes are decoded from the next state so the flops line up with the state register
    always_comb begin
        cs_d   = 1'b0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        addr_d = '0;
        d_in_d = '0;
        case (state_d)
            ST_WR_A: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_A; d_in_d = operand_q;
            end
            ST_WR_INIT: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_INIT; d_in_d = INIT_STROBE;
            end
            ST_POLL_RD: begin
                cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_DONE;
            end
            ST_RD_DATA: begin
                cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            operand_q    <= '0;
            pending_q    <= 1'b0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_error_q <= 1'b0;
            cs           <= 1'b0;
            rd           <= 1'b0;
            wr           <= 1'b0;
            addr         <= '0;
            d_in         <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= accept;
            req_ready  <= (state_d == ST_IDLE) && !accept;
            resp_valid <= (state_d == ST_RESP);
            cs         <= cs_d;
            rd         <= rd_d;
            wr         <= wr_d;
            addr       <= addr_d;
            d_in       <= d_in_d;
            if (accept) begin
                operand_q <= req_operand;
            end
            if (state_q == ST_RD_WAIT) begin
                resp_data    <= d_out;
                resp_error_q <= 1'b0;
            end else if (state_q == ST_POLL_WAIT && !d_out[0] && poll_last) begin
                resp_data    <= '0;
                resp_error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_bus_master.sv
// tb/tb_sqrt_bus_master.sv - scoreboard bench for sqrt_bus_master with a behavioural peripheral
module tb_sqrt_bus_master;

`ifdef SQRT_MASTER_TIMEOUT_EN
    localparam int TB_MAX = 4;
    localparam bit TO_EN  = 1'b1;
`else
    localparam int TB_MAX = 255;
    localparam bit TO_EN  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [15:0] req_operand;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        resp_ready;
    logic        cs, rd, wr;
    logic [4:0]  addr;
    logic [15:0] d_in;
    logic [31:0] d_out;

    sqrt_bus_master #(
        .ADDR_A   (5'h04),
        .ADDR_INIT(5'h0C),
        .ADDR_DATA(5'h10),
        .ADDR_DONE(5'h14),
        .MAX_POLLS(8'(TB_MAX))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_operand(req_operand),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_error (resp_error),
        .resp_ready (resp_ready),
        .cs         (cs),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .d_in       (d_in),
        .d_out      (d_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        logic [31:0] data;
        bit          err;
        int          lat;
        int          done_reads;
        int          data_reads;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   bus_err_cnt = 0;
    int   last_hs  = -1;
    int   lat_meas = -1;
    bit   b2b_mode = 1'b0;
    bit   resp_valid_prev = 1'b0;

    function automatic logic [31:0] isqrt(input logic [15:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return 32'(r);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // behavioural peripheral: registered read data, done after a configurable number of zero polls
    int          cfg_fail_polls = 0;
    bit          cfg_never_done = 1'b0;
    logic [15:0] p_a = '0;
    logic [31:0] p_result = '0;
    int          p_zero_left = 0;
    int          p_done_reads = 0;
    int          p_data_reads = 0;

    always @(posedge clk) begin
        d_out <= $urandom;
        if (cs && wr && addr == 5'h04) p_a <= d_in;
        if (cs && wr && addr == 5'h0C && d_in == 16'h0001) begin
            p_result     <= isqrt(p_a);
            p_zero_left  <= cfg_fail_polls;
            p_done_reads <= 0;
            p_data_reads <= 0;
        end
        if (cs && rd && addr == 5'h14) begin
            p_done_reads <= p_done_reads + 1;
            d_out <= {31'd0, (p_zero_left == 0) && !cfg_never_done};
            if (p_zero_left > 0) p_zero_left <= p_zero_left - 1;
        end
        if (cs && rd && addr == 5'h10) begin
            p_data_reads <= p_data_reads + 1;
            d_out <= p_result;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // bus protocol observer
    always @(negedge clk) begin
        if (!reset) begin
            if ((rd && wr) || (cs && !(rd ^ wr)) || (!cs && (rd || wr || addr != 0 || d_in != 0)))
                bus_err_cnt++;
            if (cs && !(addr == 5'h04 || addr == 5'h0C || addr == 5'h10 || addr == 5'h14))
                bus_err_cnt++;
        end
    end

    // response monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            resp_valid_prev = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                if (b2b_mode && last_hs >= 0) chk("b2b_accept_edge", cyc + 1, last_hs + 1);
                acc_q.push_back(cyc + 1);
            end
            if (resp_valid && !resp_valid_prev) begin
                if (acc_q.size() > 0) lat_meas = cyc - acc_q.pop_front();
                else lat_meas = -1;
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_error", resp_error, e.err);
                    chk("latency", lat_meas, e.lat);
                    chk("done_reads", p_done_reads, e.done_reads);
                    chk("data_reads", p_data_reads, e.data_reads);
                    chk("operand_written", p_a, e.op);
                end
                last_hs = cyc + 1;
            end
            resp_valid_prev = resp_valid;
        end
    end

    task automatic issue(input logic [15:0] op, input int fails, input bit never_done);
        exp_t e;
        bit   to;
        int   n;
        to = never_done || (TO_EN && fails >= TB_MAX);
        e.op         = op;
        e.data       = to ? 32'd0 : isqrt(op);
        e.err        = to;
        e.lat        = to ? 3 + 2 * TB_MAX : 7 + 2 * fails;
        e.done_reads = to ? TB_MAX : fails + 1;
        e.data_reads = to ? 0 : 1;
        @(negedge clk);
        cfg_fail_polls = fails;
        cfg_never_done = never_done;
        exp_q.push_back(e);
        req_valid   = 1'b1;
        req_operand = op;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_operand = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done_read(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            ok = cs && rd && addr == 5'h14;
            n++;
        end
        if (!ok) chk("poll_not_seen", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit          ok;
        bit          bp_ok;
        logic [31:0] held;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_operand = '0;
        resp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus", {cs, rd, wr, addr, d_in}, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_resp", {resp_valid, resp_error, resp_data}, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_reset", req_ready, 1);

        // basic transaction
        issue(16'h0441, 0, 1'b0);
        drain();

        // perfect squares back to back
        b2b_mode = 1'b1;
        last_hs  = -1;
        issue(16'd0, 0, 1'b0);
        issue(16'd1, 0, 1'b0);
        issue(16'd65025, 0, 1'b0);
        drain();
        b2b_mode = 1'b0;

        // backpressure
        resp_ready = 1'b0;
        issue(16'd50000, 1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = resp_valid;
        end
        chk("bp_resp_seen", ok, 1);
        held  = resp_data;
        bp_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data != held || resp_error || cs || req_ready) bp_ok = 1'b0;
        end
        chk("bp_stable", bp_ok, 1);
        resp_ready = 1'b1;
        drain();

        // slow done: five polls
        issue(16'd12345, 4, 1'b0);
        drain();

        // randomized operands and poll delays
        for (int i = 0; i < 12; i++) begin
            issue(16'($urandom), int'($urandom_range(0, 3)), 1'b0);
            drain();
        end
        issue(16'hFFFF, 0, 1'b0);
        drain();

`ifdef SQRT_MASTER_TIMEOUT_EN
        issue(16'd400, 0, 1'b1);
        drain();
        cfg_never_done = 1'b0;
`endif

        // reset while waiting on a poll, then while a read strobe is on the bus
        issue(16'd999, 3, 1'b0);
        wait_done_read(ok);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_wait_bus", {cs, rd, wr}, 0);
        chk("rst_wait_ready", {req_ready, resp_valid}, 0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 chk("rst_wait_ready_after", req_ready, 1);

        issue(16'd2500, 2, 1'b0);
        wait_done_read(ok);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_strobe_drop", {cs, rd, wr, addr}, 0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 chk("rst_rd_ready_after", req_ready, 1);

        issue(16'd4096, 1, 1'b0);
        drain();

        chk("bus_protocol_errors", bus_err_cnt, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
